// File: rtl/axis_fifo_pkg.sv
// Shared defaults and the level-width helper for the AXI-Stream packet FIFO.
package axis_fifo_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int ADDR_W_DEF    = 11;
  localparam int PKT_MODE_DEF  = 0;
  localparam int AE_THRESH_DEF = 4;
  localparam int AF_MARGIN_DEF = 4;

  // Level must represent 0..DEPTH inclusive, hence one bit wider than the pointers.
  function automatic int lvl_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port RAM, synchronous write and registered read; the read register
// doubles as the FIFO output stage, so it is resettable and only loads on re.
module axis_fifo_ram #(
  parameter int WIDTH  = 9,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with optional store-and-forward gating, level/packet counters
// and registered almost-full/almost-empty flags.
module axis_pkt_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int PKT_MODE  = PKT_MODE_DEF,
  parameter int AF_THRESH = (2 ** ADDR_W) - AF_MARGIN_DEF,
  parameter int AE_THRESH = AE_THRESH_DEF
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [ADDR_W:0]   level,
  output logic [ADDR_W:0]   pkt_count,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam int LVL_W = lvl_w(ADDR_W);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(2 ** ADDR_W);
  localparam logic [LVL_W-1:0] AF_L    = LVL_W'(AF_THRESH);
  localparam logic [LVL_W-1:0] AE_L    = LVL_W'(AE_THRESH);

  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0]  level_q, level_d, pkt_count_q, pkt_count_d, mem_cnt;
  logic              out_valid_q, out_valid_d, open_q, open_d;
  logic              af_q, af_d, ae_q, ae_d;
  logic              push, pop, load, gate;
  logic [DATA_W:0]   rd_word;

  assign s_axis_tready = !areset && (level_q < DEPTH_L);
  assign m_axis_tvalid = out_valid_q && gate;
  assign m_axis_tdata  = rd_word[DATA_W-1:0];
  assign m_axis_tlast  = rd_word[DATA_W];
  assign level         = level_q;
  assign pkt_count     = pkt_count_q;
  assign almost_full   = af_q;
  assign almost_empty  = ae_q;

  // Store-and-forward opens on a complete packet, mid-packet, or when a full FIFO
  // holds no tlast (oversize packet would otherwise deadlock).
  always_comb begin
    if (PKT_MODE == 0) gate = 1'b1;
    else               gate = (pkt_count_q != '0) || open_q || (level_q == DEPTH_L);
  end

  always_comb begin
    push    = s_axis_tvalid && s_axis_tready;
    pop     = m_axis_tvalid && m_axis_tready;
    // Beats still in RAM, i.e. not yet moved into the output register.
    mem_cnt = level_q - LVL_W'(out_valid_q);
    load    = (mem_cnt != '0) && (!out_valid_q || pop);

    wptr_d = push ? wptr_q + ADDR_W'(1) : wptr_q;
    rptr_d = load ? rptr_q + ADDR_W'(1) : rptr_q;

    level_d = level_q;
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);

    pkt_count_d = pkt_count_q;
    if ((push && s_axis_tlast) && !(pop && m_axis_tlast))
      pkt_count_d = pkt_count_q + LVL_W'(1);
    else if (!(push && s_axis_tlast) && (pop && m_axis_tlast))
      pkt_count_d = pkt_count_q - LVL_W'(1);

    out_valid_d = load || (out_valid_q && !pop);
    open_d      = pop ? !m_axis_tlast : open_q;
    af_d        = level_d >= AF_L;
    ae_d        = level_d <= AE_L;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      pkt_count_q <= '0;
      out_valid_q <= 1'b0;
      open_q      <= 1'b0;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      pkt_count_q <= pkt_count_d;
      out_valid_q <= out_valid_d;
      open_q      <= open_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
    end
  end

  axis_fifo_ram #(
    .WIDTH  (DATA_W + 1),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (aclk),
    .rst   (areset),
    .we    (push),
    .waddr (wptr_q),
    .wdata ({s_axis_tlast, s_axis_tdata}),
    .re    (load),
    .raddr (rptr_q),
    .rdata (rd_word)
  );

endmodule
